// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared types for the memory-stage load/store unit
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    LS_NONE    = 3'd0,
    LS_BTYE    = 3'd1,
    LS_BTYE_U  = 3'd2,
    LS_HALFW   = 3'd3,
    LS_HALFW_U = 3'd4,
    LS_WORD    = 3'd5
  } ls_flag_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // Byte accesses can never be misaligned; LS_NONE never touches the bus.
  function automatic logic is_misaligned(ls_flag_t flag, logic [1:0] offset);
    case (flag)
      LS_HALFW, LS_HALFW_U: return offset[0];
      LS_WORD:              return offset != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ls_align.sv
// rtl/ls_align.sv - store lane replication/strobes and load shift+extend
module ls_align
  import load_store_unit_pkg::*;
(
  input  ls_flag_t    ls_flag,
  input  logic        mem_write,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output msize_t      size,
  output logic [3:0]  strobe,
  output logic [31:0] lane_data,
  output logic [31:0] load_value
);

  logic [31:0] shifted;
  logic [3:0]  lane_mask;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    size       = MSIZE4;
    lane_mask  = 4'hF;
    lane_data  = wdata;
    load_value = shifted;
    case (ls_flag)
      LS_BTYE, LS_BTYE_U: begin
        size       = MSIZE1;
        lane_mask  = 4'b0001 << offset;
        lane_data  = {4{wdata[7:0]}};
        load_value = (ls_flag == LS_BTYE) ? {{24{shifted[7]}}, shifted[7:0]}
                                          : {24'd0, shifted[7:0]};
      end
      LS_HALFW, LS_HALFW_U: begin
        size       = MSIZE2;
        lane_mask  = 4'b0011 << offset;
        lane_data  = {2{wdata[15:0]}};
        load_value = (ls_flag == LS_HALFW) ? {{16{shifted[15]}}, shifted[15:0]}
                                           : {16'd0, shifted[15:0]};
      end
      default: ;
    endcase
    strobe = mem_write ? lane_mask : 4'b0000;
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory stage: one bus transaction per load/store, result to writeback
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_ls_flag,
  input  logic        in_mem_write,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_misaligned
);

  lsu_state_t  state, state_nxt;
  ls_flag_t    flag_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] result_q;
  logic        mis_q;

  ls_flag_t    in_flag;
  logic        in_mis;
  logic        accept;
  logic        capture;
  msize_t      size;
  logic [31:0] load_value;

  assign in_flag = ls_flag_t'(in_ls_flag);
  assign in_mis  = is_misaligned(in_flag, in_addr[1:0]);

  ls_align u_align (
    .ls_flag    (flag_q),
    .mem_write  (write_q),
    .offset     (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (dresp_data),
    .size       (size),
    .strobe     (dreq_strobe),
    .lane_data  (dreq_data),
    .load_value (load_value)
  );

  assign dreq_addr      = addr_q;
  assign dreq_size      = size;
  assign out_result     = result_q;
  assign out_misaligned = mis_q;

  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    dreq_valid = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = (in_flag == LS_NONE || in_mis) ? DONE : REQ;
        end
      end
      REQ: begin
        dreq_valid = 1'b1;
        if (dresp_addr_ok) begin
          capture   = dresp_data_ok;
          state_nxt = dresp_data_ok ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (dresp_data_ok) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      flag_q   <= LS_NONE;
      write_q  <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      result_q <= 32'd0;
      mis_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        flag_q   <= in_flag;
        write_q  <= in_mem_write;
        addr_q   <= in_addr;
        wdata_q  <= in_wdata;
        result_q <= (in_flag == LS_NONE) ? in_addr : 32'd0;
        mis_q    <= (in_flag != LS_NONE) && in_mis;
      end
      // Stores complete with a zero result once the bus reports done.
      if (capture) result_q <= write_q ? 32'd0 : load_value;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - table-driven scoreboard bench for load_store_unit
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_ls_flag;
  logic        in_mem_write;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_misaligned;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_ls_flag     (in_ls_flag),
    .in_mem_write   (in_mem_write),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .dreq_valid     (dreq_valid),
    .dreq_addr      (dreq_addr),
    .dreq_size      (dreq_size),
    .dreq_strobe    (dreq_strobe),
    .dreq_data      (dreq_data),
    .dresp_addr_ok  (dresp_addr_ok),
    .dresp_data_ok  (dresp_data_ok),
    .dresp_data     (dresp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_misaligned (out_misaligned)
  );

  typedef struct {
    logic [2:0]  flag;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus;
    int          adly;
    int          ddly;
    int          hold;
    logic [31:0] exp_res;
    logic        exp_mis;
    logic        exp_req;
    logic [3:0]  exp_strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_size;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        mis;
  } sb_t;

  vec_t vecs[16];
  sb_t  sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   cyc;
    sb_t  e;
    string tag;
    tag = $sformatf("v%0d", idx);
    in_ls_flag   = v.flag;
    in_mem_write = v.wr;
    in_addr      = v.addr;
    in_wdata     = v.wdata;
    in_valid     = 1'b1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    sb_q.push_back('{v.exp_res, v.exp_mis});
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_addr  = 32'hXXXX_XXXX;
    cyc      = 1;
    if (v.exp_req) begin
      repeat (v.adly) begin
        chk({tag, " wait dreq_valid"}, 32'(dreq_valid), 32'd1);
        chk({tag, " wait dreq_addr"}, dreq_addr, v.addr);
        chk({tag, " wait dreq_strobe"}, 32'(dreq_strobe), 32'(v.exp_strb));
        @(posedge clk); #1;
        cyc++;
      end
      chk({tag, " dreq_valid"}, 32'(dreq_valid), 32'd1);
      chk({tag, " dreq_addr"}, dreq_addr, v.addr);
      chk({tag, " dreq_strobe"}, 32'(dreq_strobe), 32'(v.exp_strb));
      chk({tag, " dreq_size"}, 32'(dreq_size), 32'(v.exp_size));
      if (v.wr) chk({tag, " dreq_data"}, dreq_data, v.exp_data);
      dresp_addr_ok = 1'b1;
      dresp_data_ok = (v.ddly == 0);
      dresp_data    = v.bus;
      @(posedge clk); #1;
      cyc++;
      dresp_addr_ok = 1'b0;
      dresp_data_ok = 1'b0;
      if (v.ddly > 0) begin
        chk({tag, " dreq_valid after addr_ok"}, 32'(dreq_valid), 32'd0);
        repeat (v.ddly - 1) begin
          @(posedge clk); #1;
          cyc++;
        end
        dresp_data_ok = 1'b1;
        @(posedge clk); #1;
        cyc++;
        dresp_data_ok = 1'b0;
      end
    end else begin
      chk({tag, " no dreq_valid"}, 32'(dreq_valid), 32'd0);
    end
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    if (v.exp_lat > 0) chk({tag, " latency"}, 32'(cyc), 32'(v.exp_lat));
    e = sb_q.pop_front();
    chk({tag, " out_result"}, out_result, e.res);
    chk({tag, " out_misaligned"}, 32'(out_misaligned), 32'(e.mis));
    repeat (v.hold) begin
      @(posedge clk); #1;
      chk({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold out_result"}, out_result, e.res);
      chk({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid cleared"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    //          flag        wr    addr          wdata         bus          ad dd ho exp_res       mis   req   strb     data          size lat
    vecs[0]  = '{LS_WORD,   1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 1'b0, 1'b1, 4'b0000, 32'h0,        2'd2, 2};
    vecs[1]  = '{LS_BTYE,   1'b0, 32'h103, 32'h0,        32'h80FF0000, 0, 0, 0, 32'hFFFFFF80, 1'b0, 1'b1, 4'b0000, 32'h0,        2'd0, 2};
    vecs[2]  = '{LS_BTYE_U, 1'b0, 32'h103, 32'h0,        32'h80FF0000, 0, 0, 0, 32'h00000080, 1'b0, 1'b1, 4'b0000, 32'h0,        2'd0, 2};
    vecs[3]  = '{LS_HALFW,  1'b0, 32'h102, 32'h0,        32'h80FF0000, 0, 0, 0, 32'hFFFF80FF, 1'b0, 1'b1, 4'b0000, 32'h0,        2'd1, 2};
    vecs[4]  = '{LS_BTYE,   1'b1, 32'h201, 32'h12345678, 32'h0,        0, 0, 0, 32'h0,        1'b0, 1'b1, 4'b0010, 32'h78787878, 2'd0, 2};
    vecs[5]  = '{LS_HALFW,  1'b1, 32'h202, 32'h12345678, 32'h0,        0, 0, 0, 32'h0,        1'b0, 1'b1, 4'b1100, 32'h56785678, 2'd1, 2};
    vecs[6]  = '{LS_WORD,   1'b0, 32'h102, 32'h0,        32'h0,        0, 0, 0, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        2'd2, 1};
    vecs[7]  = '{LS_NONE,   1'b0, 32'h55,  32'h0,        32'h0,        0, 0, 0, 32'h55,       1'b0, 1'b0, 4'b0000, 32'h0,        2'd0, 1};
    vecs[8]  = '{LS_WORD,   1'b1, 32'h300, 32'hCAFEF00D, 32'h0,        1, 1, 0, 32'h0,        1'b0, 1'b1, 4'b1111, 32'hCAFEF00D, 2'd2, 0};
    vecs[9]  = '{LS_HALFW_U,1'b0, 32'h101, 32'h0,        32'h0,        0, 0, 0, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        2'd1, 1};
    vecs[10] = '{LS_HALFW_U,1'b0, 32'h100, 32'h0,        32'h12348765, 0, 0, 0, 32'h00008765, 1'b0, 1'b1, 4'b0000, 32'h0,        2'd1, 2};
    vecs[11] = '{LS_BTYE,   1'b0, 32'h100, 32'h0,        32'h0000007F, 0, 0, 0, 32'h0000007F, 1'b0, 1'b1, 4'b0000, 32'h0,        2'd0, 2};
    vecs[12] = '{LS_NONE,   1'b1, 32'hAABBCCDD, 32'h1,   32'h0,        0, 0, 0, 32'hAABBCCDD, 1'b0, 1'b0, 4'b0000, 32'h0,        2'd0, 1};
    vecs[13] = '{LS_BTYE,   1'b1, 32'h203, 32'h000000AB, 32'h0,        0, 0, 0, 32'h0,        1'b0, 1'b1, 4'b1000, 32'hABABABAB, 2'd0, 2};
    vecs[14] = '{LS_WORD,   1'b0, 32'h104, 32'h0,        32'h11223344, 3, 2, 4, 32'h11223344, 1'b0, 1'b1, 4'b0000, 32'h0,        2'd2, 0};
    vecs[15] = '{LS_HALFW,  1'b1, 32'h203, 32'h5555,     32'h0,        0, 0, 0, 32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        2'd1, 1};

    reset         = 1'b1;
    in_valid      = 1'b0;
    in_ls_flag    = 3'd0;
    in_mem_write  = 1'b0;
    in_addr       = 32'd0;
    in_wdata      = 32'd0;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = 32'd0;
    out_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset dreq_valid", 32'(dreq_valid), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_result", out_result, 32'd0);
    chk("reset out_misaligned", 32'(out_misaligned), 32'd0);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Reset while waiting for data: the late data_ok must not produce a result.
    in_ls_flag   = LS_WORD;
    in_mem_write = 1'b0;
    in_addr      = 32'h108;
    in_valid     = 1'b1;
    @(posedge clk); #1;
    in_valid      = 1'b0;
    dresp_addr_ok = 1'b1;
    @(posedge clk); #1;
    dresp_addr_ok = 1'b0;
    chk("rst-mid in WAIT dreq_valid", 32'(dreq_valid), 32'd0);
    chk("rst-mid in WAIT in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst-mid in_ready", 32'(in_ready), 32'd1);
    chk("rst-mid out_result", out_result, 32'd0);
    dresp_data_ok = 1'b1;
    dresp_data    = 32'h0BADF00D;
    @(posedge clk); #1;
    dresp_data_ok = 1'b0;
    repeat (3) begin
      chk("rst-mid stale out_valid", 32'(out_valid), 32'd0);
      chk("rst-mid stale in_ready", 32'(in_ready), 32'd1);
      chk("rst-mid stale dreq_valid", 32'(dreq_valid), 32'd0);
      @(posedge clk); #1;
    end
    run_vec(vecs[0], 100);

    if (sb_q.size() != 0) chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
